// File: rtl/axis_block_reducer_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_block_reducer_if
// Purpose  : Sample-in / result-out stream handshake bundle for the reducer.
// Revision : 1.0 - initial release
// ============================================================================
interface axis_block_reducer_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int MAX_COUNT_LOG = 8
);
    logic                                input_valid;
    logic                                input_ready;
    logic [DATA_WIDTH-1:0]               input_data;
    logic                                output_valid;
    logic                                output_ready;
    logic [DATA_WIDTH+MAX_COUNT_LOG-1:0] output_data;

    modport master (
        output input_valid, input_data, output_ready,
        input  input_ready, output_valid, output_data
    );

    modport slave (
        input  input_valid, input_data, output_ready,
        output input_ready, output_valid, output_data
    );
endinterface
`default_nettype wire

// File: rtl/axis_block_reducer.sv
`default_nettype none
// ============================================================================
// Module   : axis_block_reducer
// Purpose  : Reduces blocks of 2^L stream samples to one sum/avg/max/min word.
// Revision : 1.0 - initial release
// ============================================================================
module axis_block_reducer #(
    parameter int DATA_WIDTH    = 16,
    parameter int MAX_COUNT_LOG = 8,
    parameter int IS_SIGNED     = 0,
    parameter int ROUND         = 0
) (
    input  wire logic                                   clk,
    input  wire logic                                   rst,
    input  wire logic [$clog2(MAX_COUNT_LOG+1)-1:0]     cfg_count_log,
    input  wire logic [1:0]                             cfg_mode,
    axis_block_reducer_if.slave                         bus
);
    localparam int c_acc_w = DATA_WIDTH + MAX_COUNT_LOG;
    localparam int c_log_w = $clog2(MAX_COUNT_LOG + 1);
    localparam int c_cnt_w = MAX_COUNT_LOG + 1;
    localparam logic [c_log_w-1:0] c_max_log  = c_log_w'(MAX_COUNT_LOG);
    localparam logic [1:0]         c_mode_sum = 2'b00;
    localparam logic [1:0]         c_mode_avg = 2'b01;
    localparam logic [1:0]         c_mode_max = 2'b10;
    localparam logic [1:0]         c_mode_min = 2'b11;

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_log_w-1:0] r_log;
    logic [1:0]         r_mode;
    logic [c_acc_w-1:0] r_acc;
    logic [c_acc_w-1:0] r_out_data;
    logic               r_out_valid;

    logic               w_first;
    logic [c_log_w-1:0] w_log_sat;
    logic [c_log_w-1:0] w_log;
    logic [1:0]         w_mode;
    logic [c_cnt_w-1:0] w_last_idx;
    logic               w_last;
    logic               w_accept;
    logic [c_acc_w-1:0] w_sample;
    logic               w_greater;
    logic [c_acc_w-1:0] w_acc_next;
    logic [c_acc_w-1:0] w_half;
    logic [c_acc_w-1:0] w_rounded;
    logic [c_acc_w-1:0] w_avg;
    logic [c_acc_w-1:0] w_result;

    // Block parameters come from cfg only on the first sample; afterwards the latched copy rules.
    assign w_first    = (r_cnt == '0);
    assign w_log_sat  = (cfg_count_log > c_max_log) ? c_max_log : cfg_count_log;
    assign w_log      = w_first ? w_log_sat : r_log;
    assign w_mode     = w_first ? cfg_mode  : r_mode;
    assign w_last_idx = ({{(c_cnt_w-1){1'b0}}, 1'b1} << w_log) - 1'b1;
    assign w_last     = (r_cnt == w_last_idx);

    assign bus.input_ready  = !(r_out_valid && !bus.output_ready && w_last);
    assign w_accept         = bus.input_valid && bus.input_ready;
    assign bus.output_valid = r_out_valid;
    assign bus.output_data  = r_out_data;

    assign w_half    = ((ROUND != 0) && (w_log != '0))
                     ? ({{(c_acc_w-1){1'b0}}, 1'b1} << (w_log - 1'b1)) : '0;
    assign w_rounded = w_acc_next + w_half;

    generate
        if (IS_SIGNED != 0) begin : g_signed
            assign w_sample  = {{MAX_COUNT_LOG{bus.input_data[DATA_WIDTH-1]}}, bus.input_data};
            assign w_greater = $signed(w_sample) > $signed(r_acc);
            assign w_avg     = $signed(w_rounded) >>> w_log;
        end else begin : g_unsigned
            assign w_sample  = {{MAX_COUNT_LOG{1'b0}}, bus.input_data};
            assign w_greater = w_sample > r_acc;
            assign w_avg     = w_rounded >> w_log;
        end
    endgenerate

    always_comb begin
        w_acc_next = w_sample;
        if (!w_first) begin
            case (w_mode)
                c_mode_sum, c_mode_avg: w_acc_next = r_acc + w_sample;
                c_mode_max:             w_acc_next = w_greater ? w_sample : r_acc;
                c_mode_min:             w_acc_next = w_greater ? r_acc : w_sample;
                default:                w_acc_next = w_sample;
            endcase
        end
    end

    always_comb begin
        w_result = w_acc_next;
        if (w_mode == c_mode_avg) begin
            w_result = w_avg;
        end
    end

    // A completing sample is only accepted once the output slot is free or draining this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_log       <= '0;
            r_mode      <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc <= w_acc_next;
                if (w_first) begin
                    r_log  <= w_log_sat;
                    r_mode <= cfg_mode;
                end
                if (w_last) begin
                    r_cnt      <= '0;
                    r_out_data <= w_result;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_accept && w_last) begin
                r_out_valid <= 1'b1;
            end else if (bus.output_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire
